muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU. It owns the architectural HI/LO registers and runs an iterative shift-add multiply or restoring divide over N cycles. It sits beside the single-cycle ALU in EX. While an operation is in flight, it drives a stall request to the pipeline hazard logic. HI/LO values are read by MFHI/MFLO through the Hi/Lo outputs.

Parameters:
N, 32, operand width. HI and LO are each N bits; iteration count is N.
CW, 6, iteration counter width; must be at least clog2(N)+1.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
Start  in  1  launch operation from EX; honoured only in IDLE
Op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
A  in  N  rs operand (multiplicand / dividend)
B  in  N  rt operand (multiplier / divisor)
Cancel  in  1  exception flush; aborts in-flight operation
MtHi  in  1  MTHI write request
MtLo  in  1  MTLO write request
MtData  in  N  MTHI/MTLO data
MfAccess  in  1  an MFHI/MFLO is in EX/ID and needs HI/LO
Hi  out  N  HI register
Lo  out  N  LO register
Busy  out  1  state != IDLE
Done  out  1  one-cycle pulse; HI/LO were updated on the previous edge
Stall  out  1  combinational: Busy & (Start | MfAccess | MtHi | MtLo)

Behaviour:
- Reset:
  - State = IDLE; Hi = Lo = 0; Busy = Done = 0.
  - Counter and work registers are cleared.
  - Reset overrides Cancel, Start and Mt writes in the same cycle.
- States: IDLE -> PREP -> CALC -> FIX -> IDLE.
- IDLE:
  - Start = 1: latch Op, A and B; go to PREP.
  - Else MtHi writes MtData to Hi, and/or MtLo writes MtData to Lo, at the next edge. Both may assert together.
  - Start together with MtHi/MtLo: Start wins and the Mt writes are dropped.
- PREP (1 cycle):
  - Signed ops: take magnitudes of A and B, and record the result signs.
    - Product sign = sA ^ sB.
    - Quotient sign = sA ^ sB; remainder sign = sA.
  - Unsigned ops: use raw values with signs = 0.
  - Counter loaded with N-1. Go to CALC.
- CALC (exactly N cycles):
  - MUL: 2N-bit accumulator, one shift-add step per cycle, LSB first.
  - DIV: restoring divide, one quotient bit per cycle, MSB first. Partial remainder is N+1 bits.
  - Counter decrements each cycle; go to FIX in the cycle the counter is 0.
- FIX (1 cycle):
  - Apply two's-complement sign correction.
  - MUL: {Hi,Lo} = product.
  - DIV: Lo = quotient, Hi = remainder.
  - Written at the edge leaving FIX; go to IDLE; Done = 1 in the following cycle.
- Latency:
  - Start sampled at edge E0; Hi/Lo updated at edge E(N+2), i.e. E34 for N=32.
  - Busy is high from after E0 through E(N+2).
  - Fixed latency for every op and operand value.
- Divide by zero (B = 0): detected in PREP. The result is forced to Lo = all-ones, Hi = A (original signed A). Full latency still applies.
- Signed overflow (0x80000000 / 0xFFFFFFFF): Lo = 0x80000000, Hi = 0; no trap.
- Busy-time inputs:
  - Start, MtHi and MtLo are ignored while Busy; Stall holds the pipeline so they are re-presented later.
  - MfAccess while Busy asserts Stall.
- Cancel:
  - In any non-IDLE state: return to IDLE at the next edge. Hi/Lo are unchanged and Done is not pulsed.
  - Cancel in the FIX cycle also suppresses the write.
  - In IDLE, Cancel drops a same-cycle Start.
- Done and Start: Done does not block Start. A new Start in the Done cycle is accepted, since the state is already IDLE.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 -> after 34 edges Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Done pulses once; Busy high for 34 cycles.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Then MULT with the same operands -> Hi=0, Lo=1.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU with the same operands -> Lo=0x7FFFFFFC, Hi=1.
- DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0. DIVU A=0x1234, B=0 -> Lo=0xFFFFFFFF, Hi=0x00001234.
- Busy-time inputs during DIV:
  - MtHi=1 with 0xAAAA at cycle 5 -> Stall=1 and Hi not written.
  - MfAccess at cycle 20 -> Stall=1.
  - Start held at cycle 10 -> Stall=1; the held Start is accepted only after Done.
- Preload Hi=0x11, Lo=0x22 via MtHi/MtLo in IDLE. Start MULT, then:
  - Cancel at cycle 10 -> IDLE next edge, Hi/Lo still 0x11/0x22, no Done.
  - Separately, reset at cycle 20 -> Hi=Lo=0, Busy=0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Purpose : iterative MIPS MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers.
// Latency : Start sampled at E0, HI/LO written at E(N+2), Done pulses the cycle after; fixed for all ops.
// Backpr. : Stall tells the pipeline to hold Start/MtHi/MtLo/MfAccess while an operation is in flight.
module muldiv_sequencer #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Start,
  input  logic [1:0]   Op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cancel,
  input  logic         MtHi,
  input  logic         MtLo,
  input  logic [N-1:0] MtData,
  input  logic         MfAccess,
  output logic [N-1:0] Hi,
  output logic [N-1:0] Lo,
  output logic         Busy,
  output logic         Done,
  output logic         Stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Control strobes decoded from the state machine
  logic accept;     // latch a new operation
  logic mt_en;      // MTHI/MTLO may write this cycle
  logic load_prep;  // PREP: load magnitudes into the work registers
  logic step;       // CALC: one iteration
  logic commit;     // FIX: write the corrected result to HI/LO

  // Operation latched at Start
  logic [1:0]   op_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;

  // Iteration state
  logic [CW-1:0] cnt;
  logic [N-1:0]  opnd;     // multiplicand or divisor magnitude
  logic [N-1:0]  work_hi;  // product upper half or partial remainder
  logic [N-1:0]  work_lo;  // multiplier/product lower half or dividend/quotient
  logic          neg_res;  // negate product / quotient at the end
  logic          neg_rem;  // negate remainder at the end
  logic          div_zero;

  // Decoded operation and operand magnitudes
  logic         is_div;
  logic         is_signed;
  logic         sign_a;
  logic         sign_b;
  logic [N-1:0] mag_a;
  logic [N-1:0] mag_b;

  // Per-iteration arithmetic
  logic [N:0]   mul_sum;
  logic [N:0]   div_shift;
  logic [N:0]   div_diff;

  // Final sign-corrected results
  logic [2*N-1:0] prod_raw;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix;
  logic [N-1:0]   rem_fix;
  logic [N-1:0]   res_hi;
  logic [N-1:0]   res_lo;

  assign Busy  = (state != S_IDLE);
  assign Stall = Busy & (Start | MfAccess | MtHi | MtLo);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and control strobes; Cancel aborts any non-idle state without a write
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mt_en     = 1'b0;
    load_prep = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start && !Cancel) begin
          accept    = 1'b1;
          state_nxt = S_PREP;
        end else if (!Start) begin
          mt_en = 1'b1;
        end
      end
      S_PREP: begin
        load_prep = 1'b1;
        state_nxt = S_CALC;
      end
      S_CALC: begin
        step = 1'b1;
        if (cnt == '0) state_nxt = S_FIX;
      end
      S_FIX: begin
        commit    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (Cancel && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      load_prep = 1'b0;
      step      = 1'b0;
      commit    = 1'b0;
    end
  end

  // Operand decode: signed ops work on magnitudes and fix the signs in FIX
  always_comb begin
    is_div    = op_q[1];
    is_signed = ~op_q[0];
    sign_a    = is_signed & a_q[N-1];
    sign_b    = is_signed & b_q[N-1];
    mag_a     = sign_a ? (~a_q + 1'b1) : a_q;
    mag_b     = sign_b ? (~b_q + 1'b1) : b_q;
  end

  // One shift-add (LSB first) and one restoring-divide (MSB first) step
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {work_hi, work_lo[N-1]};
    div_diff  = div_shift - {1'b0, opnd};
  end

  // Sign correction and divide-by-zero override for the FIX write
  always_comb begin
    prod_raw = {work_hi, work_lo};
    prod_fix = neg_res ? (~prod_raw + 1'b1) : prod_raw;
    quo_fix  = neg_res ? (~work_lo + 1'b1) : work_lo;
    rem_fix  = neg_rem ? (~work_hi + 1'b1) : work_hi;
    if (!is_div) begin
      res_hi = prod_fix[2*N-1:N];
      res_lo = prod_fix[N-1:0];
    end else if (div_zero) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

  // Latch the operation when it is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= Op;
      a_q  <= A;
      b_q  <= B;
    end
  end

  // Work registers and iteration counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      opnd     <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (load_prep) begin
      cnt      <= CW'(N-1);
      opnd     <= is_div ? mag_b : mag_a;
      work_hi  <= '0;
      work_lo  <= is_div ? mag_a : mag_b;
      neg_res  <= sign_a ^ sign_b;
      neg_rem  <= sign_a;
      div_zero <= is_div & (b_q == '0);
    end else if (step) begin
      cnt <= cnt - CW'(1);
      if (!is_div) begin
        work_hi <= mul_sum[N:1];
        work_lo <= {mul_sum[0], work_lo[N-1:1]};
      end else if (!div_diff[N]) begin
        work_hi <= div_diff[N-1:0];
        work_lo <= {work_lo[N-2:0], 1'b1};
      end else begin
        work_hi <= div_shift[N-1:0];
        work_lo <= {work_lo[N-2:0], 1'b0};
      end
    end
  end

  // Architectural HI/LO: result write from FIX, otherwise MTHI/MTLO in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      Hi <= '0;
      Lo <= '0;
    end else if (commit) begin
      Hi <= res_hi;
      Lo <= res_lo;
    end else if (mt_en) begin
      if (MtHi) Hi <= MtData;
      if (MtLo) Lo <= MtData;
    end
  end

  // Done follows a committed write by one cycle
  always_ff @(posedge clk) begin
    if (reset) Done <= 1'b0;
    else       Done <= commit;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vectors, expected HI/LO pushed at issue,
// a monitor pops and compares on every Done pulse.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Cancel = 1'b0;
  logic        MtHi = 1'b0;
  logic        MtLo = 1'b0;
  logic [31:0] MtData = '0;
  logic        MfAccess = 1'b0;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic        Stall;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  muldiv_sequencer #(.N(32), .CW(6)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Cancel(Cancel), .MtHi(MtHi), .MtLo(MtLo), .MtData(MtData),
    .MfAccess(MfAccess), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .Stall(Stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && Done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got Hi=%h Lo=%h, expected no Done", Hi, Lo);
        end else begin
          chk("result_hi_lo", {Hi, Lo}, exp_q.pop_front());
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  // Count busy cycles until the operation completes; check the Done pulse shape
  task automatic wait_done(input string name);
    int busy_cnt = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (!Busy) break;
      busy_cnt++;
    end
    chk({name, "_busy_cycles"}, busy_cnt, 34);
    chk({name, "_done_pulse"}, Done, 1'b1);
    @(negedge clk);
    chk({name, "_done_clear"}, Done, 1'b0);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input bit with_mtlo, input logic [31:0] lo_before);
    @(negedge clk);
    Start = 1'b1; Op = op; A = a; B = b;
    if (with_mtlo) begin
      MtLo = 1'b1;
      MtData = 32'h77;
    end
    exp_q.push_back({hi, lo});
    @(posedge clk);
    #1;
    Start = 1'b0;
    MtLo = 1'b0;
    if (with_mtlo) chk({name, "_mtlo_dropped"}, Lo, lo_before);
    wait_done(name);
  endtask

  initial begin
    bit accepted;
    int done_seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_hi", Hi, 0);
    chk("reset_lo", Lo, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    MfAccess = 1'b1;
    #1;
    chk("idle_mf_no_stall", Stall, 0);
    MfAccess = 1'b0;

    // MTHI and MTLO together in IDLE
    @(negedge clk);
    MtHi = 1'b1; MtLo = 1'b1; MtData = 32'h55;
    @(negedge clk);
    MtHi = 1'b0; MtLo = 1'b0;
    chk("mt_both_hi", Hi, 32'h55);
    chk("mt_both_lo", Lo, 32'h55);

    // Arithmetic vectors
    run_op("mult_neg3x7",   MULT,  32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, 32'h55);
    run_op("multu_max",     MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, '0);
    run_op("mult_m1xm1",    MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, '0);
    run_op("mult_carry",    MULT,  32'h00012345, 32'h00010000, 32'h00000001, 32'h23450000, 1'b0, '0);
    run_op("div_neg7_2",    DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, '0);
    run_op("divu_big_2",    DIVU,  32'hFFFFFFF9, 32'h2,        32'h00000001, 32'h7FFFFFFC, 1'b0, '0);
    run_op("div_overflow",  DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, '0);
    run_op("div_7_neg2",    DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, '0);
    run_op("div_by_zero",   DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, '0);
    run_op("divu_by_zero",  DIVU,  32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF, 1'b0, '0);

    // Busy-time inputs during a DIV, with a second DIVU held on Start
    @(negedge clk);
    Start = 1'b1; Op = DIV; A = 32'hFFFFFFF9; B = 32'h2;
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    @(posedge clk);
    #1;
    Start = 1'b0;
    accepted = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      MtHi = 1'b0;
      MfAccess = 1'b0;
      if (c == 5) begin
        MtHi = 1'b1;
        MtData = 32'hAAAA;
      end
      if (c == 10) begin
        Start = 1'b1; Op = DIVU; A = 32'hFFFFFFF9; B = 32'h2;
        exp_q.push_back({32'h00000001, 32'h7FFFFFFC});
      end
      if (c == 20) MfAccess = 1'b1;
      #1;
      if (c == 5)  chk("busy_mthi_stall", Stall, 1'b1);
      if (c == 6)  chk("busy_mthi_no_write", Hi, 32'h1234);
      if (c == 10) chk("busy_start_stall", Stall, 1'b1);
      if (c == 20) chk("busy_mf_stall", Stall, 1'b1);
      if (c > 10 && !Stall) begin
        chk("held_start_after_done", Done, 1'b1);
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) chk("held_start_accept", 0, 1);
    @(posedge clk);
    #1;
    Start = 1'b0;
    chk("held_start_busy", Busy, 1'b1);
    wait_done("held_divu");

    // Preload HI/LO, then cancel a MULT mid-flight
    @(negedge clk);
    MtHi = 1'b1; MtData = 32'h11;
    @(negedge clk);
    MtHi = 1'b0; MtLo = 1'b1; MtData = 32'h22;
    @(negedge clk);
    MtLo = 1'b0;
    chk("preload_hi", Hi, 32'h11);
    chk("preload_lo", Lo, 32'h22);
    Start = 1'b1; Op = MULT; A = 32'd5; B = 32'd6;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (10) @(negedge clk);
    Cancel = 1'b1;
    @(posedge clk);
    #1;
    Cancel = 1'b0;
    chk("cancel_busy", Busy, 1'b0);
    chk("cancel_hi", Hi, 32'h11);
    chk("cancel_lo", Lo, 32'h22);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (Done) done_seen++;
    end
    chk("cancel_no_done", done_seen, 0);

    // Reset in the middle of a MULT
    @(negedge clk);
    Start = 1'b1; Op = MULT; A = 32'd5; B = 32'd6;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midreset_hi", Hi, 0);
    chk("midreset_lo", Lo, 0);
    chk("midreset_busy", Busy, 0);
    chk("midreset_done", Done, 0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (Done) done_seen++;
    end
    chk("midreset_no_done", done_seen, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
